muldiv_arbiter: RTL

Shares the core's iterative M-extension engine (mul/mulh/mulhsu/mulhu/div/divu/rem/remu, computed inside `RiscVAlu`) between two requesters, port A and port B. Port A is the integer pipeline and port B is a second issue slot or the debug unit. The block arbitrates round-robin, latches operands, holds the engine's opcode and operand inputs stable for the whole iteration, and captures the result. It returns the result on a valid/ready response channel and flags a watchdog timeout.

---
 rtl/muldiv_arbiter_pkg.sv | 26 ++
 rtl/muldiv_arbiter_rr_pick2.sv | 15 +
 rtl/muldiv_arbiter.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/muldiv_arbiter_pkg.sv
// Shared types and constants for the two-port M-extension engine arbiter.
package muldiv_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_t;

    localparam logic [6:0] MULDIV_FUNCT7 = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

endpackage

// File: rtl/muldiv_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker; on a tie the port that was not granted last wins.
module rr_pick2
    import muldiv_arbiter_pkg::*;
(
    input  logic valid_a,
    input  logic valid_b,
    input  logic last,
    output logic grant_a,
    output logic grant_b
);

    assign grant_a = valid_a & (~valid_b | (last == OWNER_B));
    assign grant_b = valid_b & (~valid_a | (last == OWNER_A));

endmodule

// File: rtl/muldiv_arbiter.sv
// Shares one iterative mul/div engine between ports A and B: round-robin accept,
// operands held stable through the iteration, result returned on a valid/ready channel.
module muldiv_arbiter
    import muldiv_arbiter_pkg::*;
#(
    parameter int TIMEOUT = 40,
    parameter int DATA_W  = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              a_req_valid,
    output logic              a_req_ready,
    input  logic [2:0]        a_req_funct3,
    input  logic [DATA_W-1:0] a_req_s1,
    input  logic [DATA_W-1:0] a_req_s2,
    input  logic              b_req_valid,
    output logic              b_req_ready,
    input  logic [2:0]        b_req_funct3,
    input  logic [DATA_W-1:0] b_req_s1,
    input  logic [DATA_W-1:0] b_req_s2,
    output logic              a_resp_valid,
    input  logic              a_resp_ready,
    output logic              b_resp_valid,
    input  logic              b_resp_ready,
    output logic [DATA_W-1:0] resp_data,
    output logic              resp_err,
    output logic              eng_is_op_alu,
    output logic [2:0]        eng_funct3,
    output logic [6:0]        eng_funct7,
    output logic [DATA_W-1:0] eng_s1,
    output logic [DATA_W-1:0] eng_s2,
    input  logic [DATA_W-1:0] eng_rd,
    input  logic              eng_wait
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    state_t            r_state;
    owner_t            r_owner;
    owner_t            r_last_grant;
    logic [2:0]        r_funct3;
    logic [DATA_W-1:0] r_s1;
    logic [DATA_W-1:0] r_s2;
    logic [DATA_W-1:0] r_result;
    logic              r_err;
    logic [CNT_W-1:0]  r_cnt;

    logic              w_grant_a;
    logic              w_grant_b;
    logic              w_idle;
    logic              w_busy;
    logic              w_resp;
    owner_t            w_win_owner;
    logic [2:0]        w_win_funct3;
    logic [DATA_W-1:0] w_win_s1;
    logic [DATA_W-1:0] w_win_s2;
    logic              w_consumed;

    rr_pick2 u_pick (
        .valid_a (a_req_valid),
        .valid_b (b_req_valid),
        .last    (r_last_grant),
        .grant_a (w_grant_a),
        .grant_b (w_grant_b)
    );

    assign w_idle = (r_state == ST_IDLE);
    assign w_busy = (r_state == ST_BUSY);
    assign w_resp = (r_state == ST_RESP);

    // Ready is masked during reset so every output reads 0 while reset is held.
    assign a_req_ready = ~reset & w_idle & w_grant_a;
    assign b_req_ready = ~reset & w_idle & w_grant_b;

    assign w_win_owner  = w_grant_a ? OWNER_A : OWNER_B;
    assign w_win_funct3 = w_grant_a ? a_req_funct3 : b_req_funct3;
    assign w_win_s1     = w_grant_a ? a_req_s1 : b_req_s1;
    assign w_win_s2     = w_grant_a ? a_req_s2 : b_req_s2;

    assign w_consumed = ((r_owner == OWNER_A) & a_resp_ready) |
                        ((r_owner == OWNER_B) & b_resp_ready);

    // Engine inputs are zero outside BUSY so the engine drops out of its iteration and stays idle.
    assign eng_is_op_alu = w_busy;
    assign eng_funct7    = w_busy ? MULDIV_FUNCT7 : 7'd0;
    assign eng_funct3    = w_busy ? r_funct3 : 3'd0;
    assign eng_s1        = w_busy ? r_s1 : '0;
    assign eng_s2        = w_busy ? r_s2 : '0;

    assign a_resp_valid = w_resp & (r_owner == OWNER_A);
    assign b_resp_valid = w_resp & (r_owner == OWNER_B);
    assign resp_data    = r_result;
    assign resp_err     = r_err;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state      <= ST_IDLE;
            r_owner      <= OWNER_A;
            r_last_grant <= OWNER_B;
            r_funct3     <= 3'd0;
            r_s1         <= '0;
            r_s2         <= '0;
            r_result     <= '0;
            r_err        <= 1'b0;
            r_cnt        <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_grant_a | w_grant_b) begin
                        r_owner      <= w_win_owner;
                        r_last_grant <= w_win_owner;
                        r_funct3     <= w_win_funct3;
                        r_s1         <= w_win_s1;
                        r_s2         <= w_win_s2;
                        r_cnt        <= '0;
                        r_state      <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (!eng_wait) begin
                        r_result <= eng_rd;
                        r_err    <= 1'b0;
                        r_state  <= ST_RESP;
                    end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
                        // TIMEOUT-th waiting cycle: abort with an error instead of a result.
                        r_cnt    <= r_cnt + CNT_W'(1);
                        r_result <= '0;
                        r_err    <= 1'b1;
                        r_state  <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_RESP: begin
                    if (w_consumed) begin
                        r_state <= ST_IDLE;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
